// File: rtl/record_pkg.sv
// record_pkg
// Shared replay-record layout definitions. The storage backend and the
// replay unpacker both import this package, so they agree on where the
// bitmaps sit and on how long a packed unit is.
//   - RR_CHANNEL_WIDTH_BITS : width of one entry in a channel-width array
//   - rr_width_vec_t        : width array zero-extended to the max channel count
//   - layout helpers        : the bitmaps come first (logb, then loge),
//                             followed by the compacted logb payloads
//   - rr_get_len            : expected packed length for a given logb bitmap
package record_pkg;

  localparam int RR_CHANNEL_WIDTH_BITS = 8;
  localparam int RR_MAX_LOGB_CHANNELS  = 16;
  localparam int RR_WIDTH_VEC_BITS     = RR_MAX_LOGB_CHANNELS * RR_CHANNEL_WIDTH_BITS;

  typedef logic [RR_WIDTH_VEC_BITS-1:0] rr_width_vec_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } rr_state_e;

  // The logb bitmap starts at bit 0 and the loge bitmap follows it directly.
  localparam int RR_LOGB_BITMAP_LSB = 0;

  function automatic int rr_loge_bitmap_lsb(input int logb_cnt);
    return RR_LOGB_BITMAP_LSB + logb_cnt;
  endfunction

  function automatic int rr_payload_lsb(input int logb_cnt, input int loge_cnt);
    return RR_LOGB_BITMAP_LSB + logb_cnt + loge_cnt;
  endfunction

  function automatic int rr_width_of(input rr_width_vec_t widths, input int idx);
    return int'(widths[idx*RR_CHANNEL_WIDTH_BITS +: RR_CHANNEL_WIDTH_BITS]);
  endfunction

  // Gives the bit position of lane idx in the fixed-offset output bus. This is
  // the sum of the widths of all lower-indexed channels.
  function automatic int rr_lane_lsb(input rr_width_vec_t widths, input int idx);
    int sum;
    sum = 0;
    for (int i = 0; i < RR_MAX_LOGB_CHANNELS; i++) begin
      if (i < idx) sum += rr_width_of(widths, i);
    end
    return sum;
  endfunction

  // Gives the packed length of a unit: both bitmaps plus the payload of every
  // logb channel that is flagged.
  function automatic int rr_get_len(input rr_width_vec_t widths, input int logb_cnt,
                                    input int loge_cnt,
                                    input logic [RR_MAX_LOGB_CHANNELS-1:0] logb_bits);
    int sum;
    sum = logb_cnt + loge_cnt;
    for (int i = 0; i < RR_MAX_LOGB_CHANNELS; i++) begin
      if ((i < logb_cnt) && logb_bits[i]) sum += rr_width_of(widths, i);
    end
    return sum;
  endfunction

endpackage

// File: rtl/rr_unpack_offsets.sv
// rr_unpack_offsets
// Decodes the bitmaps of one packed replay unit. It forms the start offset of
// each compacted logb payload as a combinational prefix sum over the logb
// bitmap. It then extracts every payload into its fixed lane.
//   data      in  FULL_WIDTH   packed unit (bitmaps first, then payloads)
//   logb_bits out  LOGB_CNT    logb valid bitmap
//   loge_bits out  LOGE_CNT    loge valid bitmap
//   lanes     out  LANE_WIDTH  payload i at rr_lane_lsb(WIDTHS, i); a lane is
//                              meaningless when its bitmap bit is clear
module rr_unpack_offsets
  import record_pkg::*;
#(
  parameter int            LOGB_CNT     = 3,
  parameter int            LOGE_CNT     = 2,
  parameter rr_width_vec_t WIDTHS       = rr_width_vec_t'({8'd32, 8'd16, 8'd8}),
  parameter int            LANE_WIDTH   = 56,
  parameter int            FULL_WIDTH   = 61,
  parameter int            OFFSET_WIDTH = 6
) (
  input  logic [FULL_WIDTH-1:0] data,
  output logic [LOGB_CNT-1:0]   logb_bits,
  output logic [LOGE_CNT-1:0]   loge_bits,
  output logic [LANE_WIDTH-1:0] lanes
);

  localparam int LOGE_LSB    = rr_loge_bitmap_lsb(LOGB_CNT);
  localparam int PAYLOAD_LSB = rr_payload_lsb(LOGB_CNT, LOGE_CNT);

  // offs[i] is the position in data where the payload of channel i would start.
  logic [LOGB_CNT-1:0][OFFSET_WIDTH-1:0] offs;

  assign logb_bits = data[RR_LOGB_BITMAP_LSB +: LOGB_CNT];
  assign loge_bits = data[LOGE_LSB +: LOGE_CNT];
  assign offs[0]   = OFFSET_WIDTH'(PAYLOAD_LSB);

  generate
    for (genvar gi = 0; gi < LOGB_CNT; gi++) begin : g_lane
      localparam int W  = rr_width_of(WIDTHS, gi);
      localparam int LO = rr_lane_lsb(WIDTHS, gi);

      // The truncating cast keeps the low W bits of the shifted unit.
      assign lanes[LO +: W] = W'(data >> offs[gi]);

      // The next payload starts after this one only if this channel is present.
      if (gi + 1 < LOGB_CNT) begin : g_next
        assign offs[gi+1] = offs[gi] + (logb_bits[gi] ? OFFSET_WIDTH'(W) : '0);
      end
    end
  endgenerate

endmodule

// File: rtl/rr_replay_unpacker.sv
// rr_replay_unpacker
// Accepts one packed replay unit at a time. It splits the unit into
// per-channel logb payload lanes and loge events, and holds the unit until
// every flagged channel has handshaken.
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        replay unit handshake
//   in_data, in_len          packed unit and the number of bits it uses
//   logb_valid/logb_ready    per-channel payload handshake
//   logb_data                fixed-offset payload lanes
//   loge_valid/loge_ready    per-channel end-event handshake
//   len_err                  sticky: in_len disagreed with the decoded length
//   unit_cnt                 units fully retired (wraps)
module rr_replay_unpacker
  import record_pkg::*;
#(
  parameter int LOGB_CHANNEL_CNT = 3,
  parameter int LOGE_CHANNEL_CNT = 2,
  parameter logic [LOGB_CHANNEL_CNT*RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
    {8'd32, 8'd16, 8'd8},
  parameter int REPLAY_FULL_WIDTH = 61,
  localparam rr_width_vec_t WIDTHS_EXT = rr_width_vec_t'(CHANNEL_WIDTHS),
  localparam int LANE_WIDTH   = rr_lane_lsb(WIDTHS_EXT, LOGB_CHANNEL_CNT),
  localparam int FULL_WIDTH   = LANE_WIDTH + LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
  localparam int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FULL_WIDTH-1:0]       in_data,
  input  logic [OFFSET_WIDTH-1:0]     in_len,
  output logic [LOGB_CHANNEL_CNT-1:0] logb_valid,
  input  logic [LOGB_CHANNEL_CNT-1:0] logb_ready,
  output logic [LANE_WIDTH-1:0]       logb_data,
  output logic [LOGE_CHANNEL_CNT-1:0] loge_valid,
  input  logic [LOGE_CHANNEL_CNT-1:0] loge_ready,
  output logic                        len_err,
  output logic [63:0]                 unit_cnt
);

  generate
    if (FULL_WIDTH != REPLAY_FULL_WIDTH) begin : g_width_check
      $error("rr_replay_unpacker: derived FULL_WIDTH does not match the replay bus");
    end
  endgenerate

  rr_state_e                   state_reg, state_next;
  logic [LOGB_CHANNEL_CNT-1:0] pending_b_reg, pending_b_next;
  logic [LOGE_CHANNEL_CNT-1:0] pending_e_reg, pending_e_next;
  logic [LANE_WIDTH-1:0]       lanes_reg, lanes_next;
  logic                        len_err_reg, len_err_next;
  logic [63:0]                 unit_cnt_reg, unit_cnt_next;

  logic [LOGB_CHANNEL_CNT-1:0] dec_logb;
  logic [LOGE_CHANNEL_CNT-1:0] dec_loge;
  logic [LANE_WIDTH-1:0]       dec_lanes;
  logic [OFFSET_WIDTH-1:0]     exp_len;
  logic                        retiring;
  logic                        accept;
  logic                        empty_unit;

  rr_unpack_offsets #(
    .LOGB_CNT    (LOGB_CHANNEL_CNT),
    .LOGE_CNT    (LOGE_CHANNEL_CNT),
    .WIDTHS      (WIDTHS_EXT),
    .LANE_WIDTH  (LANE_WIDTH),
    .FULL_WIDTH  (FULL_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH)
  ) u_offsets (
    .data     (in_data),
    .logb_bits(dec_logb),
    .loge_bits(dec_loge),
    .lanes    (dec_lanes)
  );

  // Uses the shared length function so this check matches what the backend wrote.
  assign exp_len = OFFSET_WIDTH'(rr_get_len(WIDTHS_EXT, LOGB_CHANNEL_CNT, LOGE_CHANNEL_CNT,
                                            RR_MAX_LOGB_CHANNELS'(dec_logb)));

  assign logb_valid = pending_b_reg;
  assign loge_valid = pending_e_reg;
  assign logb_data  = lanes_reg;
  assign len_err    = len_err_reg;
  assign unit_cnt   = unit_cnt_reg;

  always_comb begin
    state_next     = state_reg;
    pending_b_next = pending_b_reg & ~logb_ready;
    pending_e_next = pending_e_reg & ~loge_ready;
    lanes_next     = lanes_reg;
    len_err_next   = len_err_reg;

    // The unit retires once every outstanding bit either handshakes now or has already cleared.
    retiring   = (state_reg == ST_HOLD) &&
                 ((pending_b_reg & ~logb_ready) == '0) &&
                 ((pending_e_reg & ~loge_ready) == '0);
    in_ready   = !rst && ((state_reg == ST_EMPTY) || retiring);
    accept     = in_valid && in_ready;
    empty_unit = accept && (dec_logb == '0) && (dec_loge == '0);

    if (retiring) state_next = ST_EMPTY;

    if (accept) begin
      pending_b_next = dec_logb;
      pending_e_next = dec_loge;
      lanes_next     = dec_lanes;
      // A unit with both bitmaps empty completes on acceptance and never enters HOLD.
      state_next     = empty_unit ? ST_EMPTY : ST_HOLD;
      if (in_len != exp_len) len_err_next = 1'b1;
    end

    // An old unit can retire in the same cycle that an empty unit is accepted,
    // so both can count together.
    unit_cnt_next = unit_cnt_reg + 64'(retiring) + 64'(empty_unit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      pending_b_reg <= '0;
      pending_e_reg <= '0;
      lanes_reg     <= '0;
      len_err_reg   <= 1'b0;
      unit_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pending_b_reg <= pending_b_next;
      pending_e_reg <= pending_e_next;
      lanes_reg     <= lanes_next;
      len_err_reg   <= len_err_next;
      unit_cnt_reg  <= unit_cnt_next;
    end
  end

endmodule

// File: tb/tb_rr_replay_unpacker.sv
// tb_rr_replay_unpacker
// Directed bench for rr_replay_unpacker with the default geometry:
// ch0=8, ch1=16, ch2=32, LOGB=3, LOGE=2, FULL_WIDTH=61. The lanes sit at
// ch0 [7:0], ch1 [23:8] and ch2 [55:24].
module tb_rr_replay_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [60:0] in_data = '0;
  logic [5:0]  in_len = '0;
  logic [2:0]  logb_valid;
  logic [2:0]  logb_ready = 3'b111;
  logic [55:0] logb_data;
  logic [1:0]  loge_valid;
  logic [1:0]  loge_ready = 2'b11;
  logic        len_err;
  logic [63:0] unit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_replay_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .logb_valid(logb_valid),
    .logb_ready(logb_ready),
    .logb_data (logb_data),
    .loge_valid(loge_valid),
    .loge_ready(loge_ready),
    .len_err   (len_err),
    .unit_cnt  (unit_cnt)
  );

  // Moves to 1 time unit after the next rising edge. Inputs are driven there
  // and outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    n_checks++; if (logb_valid !== 3'b000) begin n_fail++; $display("FAIL reset_logb_valid got %b exp 000", logb_valid); end
    n_checks++; if (loge_valid !== 2'b00) begin n_fail++; $display("FAIL reset_loge_valid got %b exp 00", loge_valid); end
    n_checks++; if (unit_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_unit_cnt got %0d exp 0", unit_cnt); end
    n_checks++; if (logb_data !== 56'd0) begin n_fail++; $display("FAIL reset_logb_data got %h exp 0", logb_data); end
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
    $display("reset released");
  endtask

  task automatic test_single_unit();
    in_data = {16'h0, 32'hDEADBEEF, 8'hA5, 2'b01, 3'b101};
    in_len = 6'd45; in_valid = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    $display("unit single: logb_valid=%b loge_valid=%b data=%h cnt=%0d", logb_valid, loge_valid, logb_data, unit_cnt);
    n_checks++; if (logb_valid !== 3'b101) begin n_fail++; $display("FAIL single_logb_valid got %b exp 101", logb_valid); end
    n_checks++; if (loge_valid !== 2'b01) begin n_fail++; $display("FAIL single_loge_valid got %b exp 01", loge_valid); end
    n_checks++; if (logb_data[7:0] !== 8'hA5) begin n_fail++; $display("FAIL single_ch0 got %h exp a5", logb_data[7:0]); end
    n_checks++; if (logb_data[55:24] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_ch2 got %h exp deadbeef", logb_data[55:24]); end
    n_checks++; if (unit_cnt !== 64'd0) begin n_fail++; $display("FAIL single_cnt_pre got %0d exp 0", unit_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_retire_ready got %b exp 1", in_ready); end
    tick();
    n_checks++; if (unit_cnt !== 64'd1) begin n_fail++; $display("FAIL single_cnt got %0d exp 1", unit_cnt); end
    n_checks++; if (logb_valid !== 3'b000) begin n_fail++; $display("FAIL single_valid_clear got %b exp 000", logb_valid); end
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL single_len_err got %b exp 0", len_err); end
  endtask

  task automatic test_backpressure();
    in_data = {16'h0, 32'hDEADBEEF, 8'hA5, 2'b01, 3'b101};
    in_len = 6'd45; in_valid = 1'b1;
    logb_ready = 3'b011;
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++; if (logb_valid !== 3'b101) begin n_fail++; $display("FAIL bp_h1_valid got %b exp 101", logb_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_h1_in_ready got %b exp 0", in_ready); end
    for (int c = 2; c <= 3; c++) begin
      tick();
      n_checks++; if (logb_valid !== 3'b100) begin n_fail++; $display("FAIL bp_h%0d_valid got %b exp 100", c, logb_valid); end
      n_checks++; if (loge_valid !== 2'b00) begin n_fail++; $display("FAIL bp_h%0d_loge got %b exp 00", c, loge_valid); end
      n_checks++; if (logb_data[55:24] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_h%0d_data got %h exp deadbeef", c, logb_data[55:24]); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_h%0d_in_ready got %b exp 0", c, in_ready); end
    end
    tick();
    logb_ready = 3'b111;
    #1;
    n_checks++; if (logb_valid !== 3'b100) begin n_fail++; $display("FAIL bp_h4_valid got %b exp 100", logb_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_h4_in_ready got %b exp 1", in_ready); end
    n_checks++; if (unit_cnt !== 64'd1) begin n_fail++; $display("FAIL bp_h4_cnt got %0d exp 1", unit_cnt); end
    tick();
    $display("unit backpressure retired: cnt=%0d", unit_cnt);
    n_checks++; if (unit_cnt !== 64'd2) begin n_fail++; $display("FAIL bp_cnt got %0d exp 2", unit_cnt); end
    n_checks++; if (logb_valid !== 3'b000) begin n_fail++; $display("FAIL bp_valid_clear got %b exp 000", logb_valid); end
  endtask

  task automatic test_back_to_back();
    in_data = {40'h0, 16'h1234, 2'b00, 3'b010};
    in_len = 6'd21; in_valid = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_a_ready got %b exp 1", in_ready); end
    tick();
    in_data = {48'h0, 8'h7F, 2'b00, 3'b001};
    in_len = 6'd13;
    #1;
    $display("unit b2b A: logb_valid=%b ch1=%h", logb_valid, logb_data[23:8]);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_b_ready got %b exp 1", in_ready); end
    n_checks++; if (logb_valid !== 3'b010) begin n_fail++; $display("FAIL b2b_a_valid got %b exp 010", logb_valid); end
    n_checks++; if (logb_data[23:8] !== 16'h1234) begin n_fail++; $display("FAIL b2b_a_ch1 got %h exp 1234", logb_data[23:8]); end
    tick();
    in_valid = 1'b0;
    #1;
    $display("unit b2b B: logb_valid=%b ch0=%h", logb_valid, logb_data[7:0]);
    n_checks++; if (logb_valid !== 3'b001) begin n_fail++; $display("FAIL b2b_b_valid got %b exp 001", logb_valid); end
    n_checks++; if (logb_data[7:0] !== 8'h7F) begin n_fail++; $display("FAIL b2b_b_ch0 got %h exp 7f", logb_data[7:0]); end
    n_checks++; if (unit_cnt !== 64'd3) begin n_fail++; $display("FAIL b2b_cnt_mid got %0d exp 3", unit_cnt); end
    tick();
    n_checks++; if (unit_cnt !== 64'd4) begin n_fail++; $display("FAIL b2b_cnt got %0d exp 4", unit_cnt); end
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL b2b_len_err got %b exp 0", len_err); end
  endtask

  task automatic test_zero_unit();
    in_data = '0; in_len = 6'd5; in_valid = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    $display("unit zero: cnt=%0d", unit_cnt);
    n_checks++; if (unit_cnt !== 64'd5) begin n_fail++; $display("FAIL zero_cnt got %0d exp 5", unit_cnt); end
    n_checks++; if (logb_valid !== 3'b000 || loge_valid !== 2'b00) begin n_fail++; $display("FAIL zero_valids got %b/%b exp 000/00", logb_valid, loge_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready_after got %b exp 1", in_ready); end
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL zero_len_err got %b exp 0", len_err); end
  endtask

  task automatic test_len_err();
    in_data = {32'h44556677, 16'h2233, 8'h11, 2'b10, 3'b111};
    in_len = 6'd40; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    $display("unit bad len: len_err=%b data=%h", len_err, logb_data);
    n_checks++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL lenerr_set got %b exp 1", len_err); end
    n_checks++; if (logb_data !== 56'h44556677_2233_11) begin n_fail++; $display("FAIL lenerr_lanes got %h exp 44556677223311", logb_data); end
    n_checks++; if (logb_valid !== 3'b111 || loge_valid !== 2'b10) begin n_fail++; $display("FAIL lenerr_valids got %b/%b exp 111/10", logb_valid, loge_valid); end
    tick();
    in_data = {48'h0, 8'h3C, 2'b00, 3'b001};
    in_len = 6'd13; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL lenerr_sticky got %b exp 1", len_err); end
    n_checks++; if (unit_cnt !== 64'd7) begin n_fail++; $display("FAIL lenerr_cnt got %0d exp 7", unit_cnt); end
  endtask

  task automatic test_reset_in_hold();
    in_data = {24'h0, 32'hCAFEF00D, 2'b00, 3'b100};
    in_len = 6'd37; in_valid = 1'b1;
    logb_ready = 3'b011;
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++; if (logb_valid !== 3'b100) begin n_fail++; $display("FAIL hrst_hold_valid got %b exp 100", logb_valid); end
    n_checks++; if (logb_data[55:24] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL hrst_ch2 got %h exp cafef00d", logb_data[55:24]); end
    rst = 1'b1;
    #1;
    n_checks++; if (logb_valid !== 3'b000) begin n_fail++; $display("FAIL hrst_valid_now got %b exp 000", logb_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hrst_in_ready got %b exp 0", in_ready); end
    tick();
    rst = 1'b0;
    logb_ready = 3'b111;
    #1;
    $display("reset during hold released: cnt=%0d len_err=%b", unit_cnt, len_err);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hrst_ready_after got %b exp 1", in_ready); end
    n_checks++; if (unit_cnt !== 64'd0) begin n_fail++; $display("FAIL hrst_cnt got %0d exp 0", unit_cnt); end
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL hrst_len_err got %b exp 0", len_err); end
    n_checks++; if (logb_data !== 56'd0) begin n_fail++; $display("FAIL hrst_data got %h exp 0", logb_data); end
    tick();
    n_checks++; if (logb_valid !== 3'b000) begin n_fail++; $display("FAIL hrst_no_replay got %b exp 000", logb_valid); end
  endtask

  initial begin
    test_reset();
    test_single_unit();
    test_backpressure();
    test_back_to_back();
    test_zero_unit();
    test_len_err();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_replay_unpacker.md
Name: rr_replay_unpacker

Overview:
- Sits directly downstream of the trace storage backend's replay output.
- Consumes the packed, variable-length replay stream (valid/ready/data/len) one logging unit at a time.
- Decodes the logb/loge valid bitmaps, extracts each compacted logb payload to a fixed per-channel lane, and presents per-channel valid/ready handshakes to the replayers.
- Holds each unit until every flagged channel has accepted, which preserves inter-unit ordering.

Parameters:
- LOGB_CHANNEL_CNT, 3, number of logb channels.
- LOGE_CHANNEL_CNT, 2, number of loge channels.
- CHANNEL_WIDTHS, {32,16,8} (index 0 = 8), packed array of RR_CHANNEL_WIDTH_BITS-wide shuffled logb payload widths.
- FULL_WIDTH, derived, sum(CHANNEL_WIDTHS) + LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT; must equal the replay bus FULL_WIDTH, otherwise elaboration error.
- OFFSET_WIDTH, derived, $clog2(FULL_WIDTH+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  replay unit valid.
- in_ready  out  1  replay unit accepted.
- in_data  in  FULL_WIDTH  packed unit.
- in_len  in  OFFSET_WIDTH  bits used in in_data.
- logb_valid  out  LOGB_CHANNEL_CNT  per-channel payload valid.
- logb_ready  in  LOGB_CHANNEL_CNT  per-channel accept.
- logb_data  out  sum(CHANNEL_WIDTHS)  channel i at fixed offset sum(CHANNEL_WIDTHS[0..i-1]).
- loge_valid  out  LOGE_CHANNEL_CNT  per-channel end-event valid.
- loge_ready  in  LOGE_CHANNEL_CNT  per-channel accept.
- len_err  out  1  sticky: in_len != decoded length.
- unit_cnt  out  64  units fully retired.

Behaviour:
- Input layout, LSB first:
  - logb bitmap [LOGB-1:0];
  - loge bitmap next;
  - then payloads of set logb channels only, packed contiguously in ascending channel index.
- Expected length = LOGB + LOGE + sum of CHANNEL_WIDTHS[i] for each set logb bit.
- Offsets are computed as a combinational prefix sum over the bitmap; the extraction shift is OFFSET_WIDTH wide.
- States: EMPTY, HOLD.
  - EMPTY: in_ready=1. On in_valid, capture the bitmaps into pending_b/pending_e and the extracted payloads into the lane registers, then go to HOLD. Outputs assert the cycle after acceptance (latency 1).
  - HOLD: logb_valid=pending_b and loge_valid=pending_e. Each bit clears on its valid&ready handshake. The data lane stays stable while its valid is high.
  - Unit retires in the cycle when (pending & ~handshake) == 0; unit_cnt increments by 1.
- Full throughput: in_ready = EMPTY | retiring-this-cycle. A new unit may be captured in the same cycle the old one retires, giving back-to-back units with no bubble; state stays HOLD.
- All-zero bitmap unit: accepted, never enters HOLD, unit_cnt increments on the accept cycle, no outputs are asserted.
- Channels are independent. There is no ordering between channels within one unit. No output of unit N+1 is asserted before unit N retires.
- len mismatch: len_err is set the cycle after accept and stays set until reset. Extraction still follows the bitmap; in_len is ignored for decode.
- unit_cnt wraps modulo 2^64.
- Reset (any time, including mid-HOLD):
  - state=EMPTY, pending=0, all valids=0, logb_data=0, len_err=0, unit_cnt=0.
  - in_ready is 0 while rst is asserted and 1 in the first cycle after deassertion.
  - A partially delivered unit is discarded.

Decomposition:
- record_pkg (shared): RR_CHANNEL_WIDTH_BITS, the layout constants (bitmap-first ordering), and a GET_LEN-style function shared with the storage backend so expected length is computed identically.
- Sub-module rr_unpack_offsets: combinational prefix-sum offsets plus the per-channel extractor, parameterised on the width array. Reusable by the validation path.

Test Plan:
All cases use defaults: widths ch0=8, ch1=16, ch2=32; LOGB=3, LOGE=2; FULL_WIDTH=61.
1. Single unit: logb=3'b101, loge=2'b01, ch0=0xA5 at [12:5], ch2=0xDEADBEEF at [44:13], len=45, all ready=1.
   -> Next cycle logb_valid=101, loge_valid=01, lanes ch0=0xA5 and ch2=0xDEADBEEF; retires in one cycle; unit_cnt=1; len_err=0.
2. Same unit with logb_ready[2]=0 for 3 cycles.
   -> ch0/loge handshake in cycle 1; ch2 valid is held 4 cycles with stable data; in_ready=0 until the ch2 handshake; unit_cnt increments on that cycle.
3. Back-to-back units (logb=010 payload 0x1234 len=21, then logb=001 payload 0x7F len=13), all ready=1.
   -> in_ready stays 1; valids in consecutive cycles; unit_cnt=2 after 3 cycles.
4. All-zero unit, len=5.
   -> No output valids; unit_cnt+1; in_ready remains 1.
5. logb=111 with len=40 (expected 61).
   -> Payloads still extracted by bitmap; len_err=1 and stays 1 across later good units.
6. Assert rst while in HOLD with pending_b=100.
   -> All valids=0 immediately; after deassert: EMPTY, in_ready=1, unit_cnt=0, len_err=0.
